// File: rtl/cp0_intc_pkg.sv
// Shared address map and helpers for the CP0 interrupt/timer unit.
package cp0_intc_pkg;

  localparam logic [3:0] CINT_COUNT    = 4'd0;
  localparam logic [3:0] CINT_CTRL     = 4'd1;
  localparam logic [3:0] CINT_PENDING  = 4'd2;
  localparam logic [3:0] CINT_TSTAT    = 4'd3;
  localparam logic [3:0] CINT_COMPARE0 = 4'd4;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] id;
    id = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (v[k]) id = 3'(k);
    end
    return id;
  endfunction

endpackage

// File: rtl/cp0_intc_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line.
module cp0_intc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        stg[k] <= stg[k-1];
      end
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt and timer unit: shared Count, N compare channels,
// level/edge hardware lines, software bits and priority encoding.
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter int unsigned N_HW        = 6,
  parameter int unsigned N_TIMER     = 1,
  parameter int unsigned TICK_DIV    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMER_LINE  = N_HW - 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_HW-1:0]   hw_int,
  input  logic              count_stall,
  input  logic              wr_en,
  input  logic [3:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic [N_HW+1:0]   status_im,
  input  logic              status_ie,
  input  logic              status_exl,
  output logic [N_HW+1:0]   ip,
  output logic              ti,
  output logic              int_sig,
  output logic [2:0]        int_id
);

  localparam int unsigned      DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [31:0]        count;
  logic [DIV_W-1:0]   div;
  logic [31:0]        compare [N_TIMER];
  logic [N_TIMER-1:0] tpend, t_clr, wr_cmp;
  logic [N_HW-1:0]    edge_mode, edge_lat, sync_q, lvl_q, rise, lat_clr;
  logic [N_HW-1:0]    line_pend, hw_pend;
  logic [1:0]         sw;
  logic [N_HW+1:0]    masked;
  logic               wr_count, wr_ctrl, wr_pend, wr_tstat;

  for (genvar j = 0; j < N_HW; j++) begin : g_sync
    cp0_intc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (hw_int[j]),
      .q      (sync_q[j])
    );
  end

  always_comb begin
    wr_count = wr_en && (addr == CINT_COUNT);
    wr_ctrl  = wr_en && (addr == CINT_CTRL);
    wr_pend  = wr_en && (addr == CINT_PENDING);
    wr_tstat = wr_en && (addr == CINT_TSTAT);
    t_clr    = wr_tstat ? wr_data[N_TIMER-1:0] : '0;
    wr_cmp   = '0;
    for (int unsigned i = 0; i < N_TIMER; i++) begin
      wr_cmp[i] = wr_en && (addr == 4'(CINT_COMPARE0 + i));
    end
    lat_clr = wr_pend ? wr_data[N_HW+1:2] : '0;
  end

  // lvl_q doubles as the previous synchronised sample for edge detection.
  assign rise      = sync_q & ~lvl_q;
  assign line_pend = (edge_mode & edge_lat) | (~edge_mode & lvl_q);

  always_comb begin
    hw_pend             = line_pend;
    hw_pend[TIMER_LINE] = line_pend[TIMER_LINE] | ti;
  end

  assign ti      = |tpend;
  assign ip      = {hw_pend, sw};
  assign masked  = ip & status_im;
  assign int_sig = (|masked) & status_ie & ~status_exl;
  assign int_id  = int_sig ? prio_enc(8'(masked)) : '0;

  always_comb begin
    rd_data = '0;
    case (addr)
      CINT_COUNT:   rd_data = count;
      CINT_CTRL:    rd_data = 32'(edge_mode);
      CINT_PENDING: rd_data = 32'(ip);
      CINT_TSTAT:   rd_data = 32'(tpend);
      default:      ;
    endcase
    for (int unsigned i = 0; i < N_TIMER; i++) begin
      if (addr == 4'(CINT_COMPARE0 + i)) rd_data = compare[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      div       <= '0;
      tpend     <= '0;
      edge_mode <= '0;
      edge_lat  <= '0;
      lvl_q     <= '0;
      sw        <= '0;
      for (int unsigned i = 0; i < N_TIMER; i++) begin
        compare[i] <= '1;
      end
    end else begin
      lvl_q <= sync_q;
      if (wr_count) begin
        count <= wr_data;
        div   <= '0;
      end else if (!count_stall) begin
        if (div == DIV_MAX) begin
          div   <= '0;
          count <= count + 32'd1;
        end else begin
          div <= div + 1'b1;
        end
      end
      if (wr_ctrl) edge_mode <= wr_data[N_HW-1:0];
      if (wr_pend) sw <= wr_data[1:0];
      // Level-mode lines keep the latch cleared; a new edge beats a W1C.
      edge_lat <= edge_mode & (rise | (edge_lat & ~lat_clr));
      for (int unsigned i = 0; i < N_TIMER; i++) begin
        if (wr_cmp[i]) compare[i] <= wr_data;
        if (t_clr[i] || wr_cmp[i]) tpend[i] <= 1'b0;
        else if (count == compare[i]) tpend[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed scenarios then randomized traffic
// compared each cycle against a behavioural model.
module tb_cp0_intc;

  localparam int NH  = 6;
  localparam int NT  = 2;
  localparam int TD  = 2;
  localparam int SS  = 2;
  localparam int TL  = NH - 1;
  localparam int NIP = NH + 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NH-1:0]   hw_int;
  logic            count_stall;
  logic            wr_en;
  logic [3:0]      addr;
  logic [31:0]     wr_data;
  logic [31:0]     rd_data;
  logic [NIP-1:0]  status_im;
  logic            status_ie;
  logic            status_exl;
  logic [NIP-1:0]  ip;
  logic            ti;
  logic            int_sig;
  logic [2:0]      int_id;

  int n_assert = 0;
  int n_fail   = 0;

  cp0_intc #(
    .N_HW(NH), .N_TIMER(NT), .TICK_DIV(TD), .SYNC_STAGES(SS), .TIMER_LINE(TL)
  ) dut (
    .clk(clk), .resetn(resetn), .hw_int(hw_int), .count_stall(count_stall),
    .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
    .ip(ip), .ti(ti), .int_sig(int_sig), .int_id(int_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: Count is the last written value plus elapsed
  // non-stalled cycles divided by TD; lines are a pure delay of hw_int.
  logic [31:0]   m_base;
  int unsigned   m_n;
  logic [31:0]   m_cmp [NT];
  logic [NT-1:0] m_tp;
  logic [NH-1:0] m_em, m_lat;
  logic [1:0]    m_sw;
  logic [NH-1:0] m_hist [SS+1];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_n / TD);
  endfunction

  function automatic logic [NIP-1:0] m_ip();
    logic [NH-1:0] hw;
    hw = (m_em & m_lat) | (~m_em & m_hist[SS]);
    hw[TL] = hw[TL] | (|m_tp);
    return {hw, m_sw};
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return m_count();
    if (ai == 1) return 32'(m_em);
    if (ai == 2) return 32'(m_ip());
    if (ai == 3) return 32'(m_tp);
    if (ai >= 4 && ai - 4 < NT) return m_cmp[ai-4];
    return 32'h0;
  endfunction

  task automatic m_edge();
    logic [31:0]   c;
    logic [NH-1:0] rs;
    logic [NT-1:0] clr;
    if (!resetn) begin
      m_base = '0; m_n = 0; m_tp = '0; m_em = '0; m_lat = '0; m_sw = '0;
      for (int i = 0; i < NT; i++) m_cmp[i] = 32'hFFFF_FFFF;
      for (int k = 0; k <= SS; k++) m_hist[k] = '0;
    end else begin
      c   = m_count();
      rs  = m_hist[SS-1] & ~m_hist[SS];
      clr = (wr_en && addr == 4'd3) ? wr_data[NT-1:0] : '0;
      for (int i = 0; i < NT; i++) begin
        if (wr_en && int'(addr) == 4 + i) clr[i] = 1'b1;
        if (clr[i]) m_tp[i] = 1'b0;
        else if (c == m_cmp[i]) m_tp[i] = 1'b1;
        if (wr_en && int'(addr) == 4 + i) m_cmp[i] = wr_data;
      end
      for (int j = 0; j < NH; j++) begin
        if (!m_em[j]) m_lat[j] = 1'b0;
        else if (rs[j]) m_lat[j] = 1'b1;
        else if (wr_en && addr == 4'd2 && wr_data[j+2]) m_lat[j] = 1'b0;
      end
      if (wr_en && addr == 4'd1) m_em = wr_data[NH-1:0];
      if (wr_en && addr == 4'd2) m_sw = wr_data[1:0];
      if (wr_en && addr == 4'd0) begin
        m_base = wr_data;
        m_n    = 0;
      end else if (!count_stall) begin
        m_n++;
      end
      for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = hw_int;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [NIP-1:0] e_ip;
    logic [NIP-1:0] e_m;
    logic           e_sig;
    logic [2:0]     e_id;
    e_ip  = m_ip();
    e_m   = e_ip & status_im;
    e_sig = (e_m != '0) && status_ie && !status_exl;
    e_id  = 3'd0;
    if (e_sig) begin
      for (int k = 0; k < NIP; k++) if (e_m[k]) e_id = 3'(k);
    end
    check("rd_data", rd_data, m_rd(addr));
    check("ip", 32'(ip), 32'(e_ip));
    check("ti", 32'(ti), 32'(|m_tp));
    check("int_sig", 32'(int_sig), 32'(e_sig));
    check("int_id", 32'(int_id), 32'(e_id));
  endtask

  // Inputs are set just after a falling edge; this checks, advances the model
  // across the rising edge, and returns at the next falling edge.
  task automatic cyc();
    #1 chk_all();
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    resetn = 1'b0; hw_int = '0; count_stall = 1'b0; wr_en = 1'b0;
    addr = '0; wr_data = '0; status_im = '0; status_ie = 1'b0; status_exl = 1'b0;
    m_edge();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Reset values
    peek(4'd0); check("rst_count", rd_data, 32'h0);
    peek(4'd4); check("rst_cmp0", rd_data, 32'hFFFF_FFFF);
    check("rst_ip", 32'(ip), 32'h0);
    check("rst_int_id", 32'(int_id), 32'h0);

    // Tick divider and wrap
    addr = 4'd0;
    repeat (10) cyc();
    peek(4'd0); check("count_after_10", rd_data, 32'd5);
    wr(4'd0, 32'hFFFF_FFFF);
    peek(4'd0); check("count_written", rd_data, 32'hFFFF_FFFF);
    cyc(); cyc();
    peek(4'd0); check("count_wrap", rd_data, 32'h0);

    // Two timer channels
    wr(4'd3, 32'h3);
    wr(4'd5, 32'd3);
    wr(4'd4, 32'd6);
    wr(4'd0, 32'd0);
    peek(4'd3);
    for (int k = 0; k < 40 && rd_data == 32'h0; k++) cyc();
    check("tstat_first", rd_data, 32'h2);
    check("ti_set", 32'(ti), 32'h1);
    check("ip_timer_line", 32'(ip[TL+2]), 32'h1);
    for (int k = 0; k < 40 && rd_data == 32'h2; k++) cyc();
    check("tstat_both", rd_data, 32'h3);
    wr(4'd3, 32'h2);
    peek(4'd3); check("tstat_w1c", rd_data, 32'h1);
    wr(4'd4, 32'd100);
    check("ti_cleared", 32'(ti), 32'h0);

    // Edge mode on line 2
    wr(4'd1, 32'h4);
    hw_int[2] = 1'b1; cyc();
    hw_int[2] = 1'b0; cyc();
    check("edge_not_yet", 32'(ip[4]), 32'h0);
    cyc();
    check("edge_latched", 32'(ip[4]), 32'h1);
    cyc(); cyc();
    check("edge_held", 32'(ip[4]), 32'h1);
    wr(4'd2, 32'h10);
    check("edge_w1c", 32'(ip[4]), 32'h0);
    hw_int[2] = 1'b1; cyc();
    hw_int[2] = 1'b0; cyc();
    wr(4'd2, 32'h10);
    check("edge_set_wins", 32'(ip[4]), 32'h1);

    // Priority and masking
    wr(4'd1, 32'h0);
    wr(4'd2, 32'h1);
    hw_int[3] = 1'b1;
    repeat (3) cyc();
    status_im = '1; status_ie = 1'b1; status_exl = 1'b0;
    #1;
    check("prio_sig", 32'(int_sig), 32'h1);
    check("prio_id", 32'(int_id), 32'd5);
    status_exl = 1'b1;
    #1;
    check("exl_sig", 32'(int_sig), 32'h0);
    check("exl_id", 32'(int_id), 32'h0);
    cyc();

    // Reset mid-count
    hw_int = '0; status_exl = 1'b0;
    wr(4'd0, 32'h1234);
    resetn = 1'b0; cyc();
    resetn = 1'b1;
    peek(4'd0); check("rst2_count", rd_data, 32'h0);
    peek(4'd3); check("rst2_tstat", rd_data, 32'h0);
    check("rst2_ip", 32'(ip), 32'h0);

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      resetn      = ($urandom_range(0, 99) != 0);
      wr_en       = ($urandom_range(0, 3) == 0);
      addr        = 4'($urandom_range(0, 8));
      wr_data     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) hw_int = hw_int ^ NH'(1 << $urandom_range(0, NH - 1));
      count_stall = ($urandom_range(0, 7) == 0);
      status_im   = NIP'($urandom);
      status_ie   = ($urandom_range(0, 3) != 0);
      status_exl  = ($urandom_range(0, 3) == 0);
      cyc();
    end
    resetn = 1'b1; wr_en = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised CP0 interrupt and timer unit that generalises the single Count/Compare timer and fixed six-line interrupt sampling of the CP0 register file. It has:
- N_TIMER compare channels on a shared Count with a configurable tick divider;
- per-line synchronisers with selectable level or edge (latched) mode;
- software interrupt bits and a highest-priority pending interrupt encoder.

It sits beside the CP0 register file. That file forwards mtc0/mfc0 accesses in this block's address window and supplies Status.IM, Status.IE and Status.EXL.

## Interface
Parameters:
- N_HW, 6, number of hardware interrupt lines (1..6)
- N_TIMER, 1, compare channels (1..4)
- TICK_DIV, 2, clk cycles per Count increment (≥1)
- SYNC_STAGES, 2, synchroniser depth on hw_int (≥1)
- TIMER_LINE, N_HW-1, hardware line index into which all timer pendings are OR-ed

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- hw_int  in  N_HW  asynchronous external interrupt requests
- count_stall  in  1  freezes Count and the divider (debug)
- wr_en  in  1  register write strobe
- addr  in  4  register address (read and write)
- wr_data  in  32  write data
- rd_data  out  32  combinational read data
- status_im  in  N_HW+2  interrupt mask
- status_ie  in  1  global enable
- status_exl  in  1  exception level
- ip  out  N_HW+2  Cause.IP view: {hw pending, sw[1:0]}
- ti  out  1  OR of timer pendings (Cause.TI)
- int_sig  out  1  unmasked interrupt present
- int_id  out  3  index of highest unmasked pending bit; highest index wins

## Operation
Register map (unmapped reads return 0; unmapped writes are ignored):
- **0 COUNT**
  - Read/write.
  - Increments by 1 when the divider reaches TICK_DIV-1 and count_stall=0.
  - Wraps from 0xFFFFFFFF to 0.
  - A write clears the divider.
- **1 CTRL**
  - bits[N_HW-1:0] edge_mode per line: 1 = edge-latched, 0 = level.
- **2 PENDING**
  - Read returns ip.
  - Write sets sw bits [1:0] directly.
  - Writing 1 to bit j+2 clears the edge latch of line j.
- **3 TSTAT**
  - Read returns per-channel timer pending in bits[N_TIMER-1:0].
  - Writing 1 clears the addressed channel's pending.
- **4+i COMPARE[i]**
  - Read/write.
  - A write clears timer pending i.

Line and timer behaviour:
- Line j in level mode: pending = synchronised input.
- Line j in edge mode: a rising edge of the synchronised input sets the latch, which holds until W1C.
- Timer pending i is set in any cycle where COUNT==COMPARE[i], unless that cycle writes COMPARE[i] or clears channel i through TSTAT.
- hw pending at TIMER_LINE = line pending | ti.
- int_sig = |(ip & status_im) & status_ie & !status_exl.
- int_id = 0 when int_sig=0.

Simultaneous events:
- Edge set and W1C clear in the same cycle: set wins.
- COUNT write and tick in the same cycle: write wins.
- Changing edge_mode from 1 to 0 drops the latch.

## Timing
- Reset values:
  - COUNT=0, divider=0, COMPARE[*]=0xFFFFFFFF
  - timer pendings=0, edge latches=0, edge_mode=0, sw=0
  - synchronisers=0, ip=0, ti=0, int_sig=0, int_id=0
- Latency:
  - A hw_int change reaches ip after SYNC_STAGES+1 cycles.
  - A COUNT==COMPARE match is visible on ti and ip one cycle after the match cycle.
  - A register write takes effect on the next clk edge. rd_data in the same cycle returns the old value.
- int_sig and int_id are combinational from the registered ip and the Status inputs. They carry no added latency.
- A reset asserted mid-operation returns every register to its reset value on the next edge. A pending request is lost.

## Structure
- Package cp0_intc_pkg holds the address constants (CINT_COUNT, CINT_CTRL, CINT_PENDING, CINT_TSTAT, CINT_COMPARE0) and a priority-encode function.
- Sub-module cp0_intc_sync: parametrised SYNC_STAGES flop chain with synchronous reset. One instance per hw line.

## Test plan
- **Tick divider:** TICK_DIV=2, reset, idle 10 cycles → COUNT reads 5. Then write COUNT=0xFFFFFFFF → reads 0 two cycles later (wrap).
- **Timer match:** COMPARE[0]=8, COUNT=0, TICK_DIV=1 → ti=1 from cycle 9, ip[TIMER_LINE+2]=1. Then write COMPARE[0]=100 → ti=0 next cycle.
- **Two channels:** N_TIMER=2, COMPARE[1]=3, COMPARE[0]=6 → TSTAT reads 2'b10 then 2'b11. W1C 2'b10 → reads 2'b01.
- **Edge mode:** edge_mode[2]=1, pulse hw_int[2] for 1 cycle → ip[4] rises SYNC_STAGES+1 cycles later and stays set. W1C PENDING bit 4 → ip[4]=0. A pulse in the same cycle as the W1C → stays 1.
- **Priority and masking:** sw=2'b01, hw line 3 pending, status_im=0xFF, ie=1, exl=0 → int_sig=1, int_id=5. Set exl=1 → int_sig=0, int_id=0.
- **Reset mid-count:** COUNT=0x1234, deassert resetn 1 cycle → COUNT=0, TSTAT=0, ip=0.
